ct_f_spsram_init_bw: RTL and testbench
======================================

Name: ct_f_spsram_init_bw

Overview:
- Parametrised single-port SRAM model for FPGA/simulation builds of the cache and TLB arrays.
- Successor to the fixed 1024x144 bit-masked single-port SRAM.
- Adds:
  - configurable depth/width and write-mask granularity
  - a hardware zero-initialisation engine (on reset or on request)
  - a selectable 1- or 2-cycle read pipeline with a read-valid strobe
- Sits beneath the L1/L2 array wrappers. Those wrappers must hold off accesses while init_busy is high.

Parameters:
- ADDR_WIDTH, 10, address bits; DEPTH = 2**ADDR_WIDTH entries.
- DATA_WIDTH, 144, bits per entry.
- WEN_GRAN, 1, data bits per write-mask bit. DATA_WIDTH % WEN_GRAN must be 0; WEN_WIDTH = DATA_WIDTH/WEN_GRAN.
- READ_LATENCY, 1, 1 or 2 cycles from read request to Q. Any other value is an elaboration error.
- INIT_ON_RESET, 1, 1 = zero-fill the array automatically after reset release.

Ports:
- forever_cpuclk  in  1  clock; all state on posedge.
- cpurst_b  in  1  asynchronous active-low reset.
- A  in  ADDR_WIDTH  access address.
- CEN  in  1  chip enable, active low.
- GWEN  in  1  global write enable, active low (0 = write, 1 = read).
- WEN  in  WEN_WIDTH  per-group write mask, active low.
- D  in  DATA_WIDTH  write data.
- Q  out  DATA_WIDTH  read data.
- q_vld  out  1  one-cycle pulse, Q updated this cycle.
- init_req  in  1  pulse; start zero-fill (honoured only in IDLE).
- init_busy  out  1  zero-fill in progress; external accesses ignored.

Behaviour:
- The clock is forever_cpuclk. Reset is cpurst_b, asynchronous and active-low.
- Storage: DEPTH x DATA_WIDTH register array, not reset. Contents are undefined until written or zero-filled.
- Reset values:
  - Q = 0, q_vld = 0, init counter = 0, pipeline valid bits = 0.
  - FSM = INIT if INIT_ON_RESET = 1, else IDLE.
  - init_busy = (FSM == INIT), so it is 1 during reset when INIT_ON_RESET = 1.
- FSM states IDLE and INIT:
  - IDLE -> INIT when init_req = 1. The counter loads 0.
  - In INIT, each cycle: mem[cnt] <= 0 (all bits, mask ignored), then cnt++.
  - INIT -> IDLE on the cycle cnt == DEPTH-1 is written. Total fill = DEPTH cycles.
  - init_busy falls the cycle after the last write.
  - init_req while in INIT is ignored (no restart, no extension).
  - Reset asserted mid-INIT aborts the fill. On release the FSM re-enters INIT (if INIT_ON_RESET) from cnt = 0.
- External access is accepted only when CEN = 0 and init_busy = 0. While busy, CEN is treated as 1: no write, no read, no q_vld.
- Write (accepted, GWEN = 0): for each group g with WEN[g] = 0, mem[A][g*WEN_GRAN +: WEN_GRAN] <= D of that group; other groups keep their value. Q and q_vld are unchanged. No write-through.
- Read (accepted, GWEN = 1):
  - Array data is sampled at the accepting edge: stage1 <= mem[A].
  - READ_LATENCY = 1: Q <= mem[A] and q_vld = 1 on the cycle after the request.
  - READ_LATENCY = 2: an extra output register; Q and q_vld = 1 two cycles after the request.
  - Back-to-back reads pipeline fully: one result per cycle, in order.
- Q holds its last read value until the next read completes. q_vld is a single-cycle pulse per read.
- Write and read to the same address on consecutive cycles: the read returns the post-write data.
- A read issued on the cycle init_req is sampled still completes normally. Init begins on the following cycle.
- An in-flight LAT=2 read completes even if INIT starts meanwhile.
- Address wrap: not applicable; every A value is in range because DEPTH is a power of two.

Test Plan:
- INIT_ON_RESET=1, ADDR_WIDTH=4: release cpurst_b -> init_busy high exactly 16 cycles. Then read addr 0..15 -> Q=0 each, q_vld one cycle after each request.
- LAT=1, WEN_GRAN=8, DATA_WIDTH=16: write A=3, D=16'hABCD, WEN=2'b10. Then read A=3 -> Q=16'h00CD (after zero-fill), q_vld on the following cycle.
- LAT=2: reads of A=1,2,3 on consecutive cycles (contents 0x11,0x22,0x33) -> Q = 0x11,0x22,0x33 on cycles +2,+3,+4, q_vld high on those three cycles only.
- Write A=5, D=0x55, WEN all 0, while init_busy=1 -> after fill completes, read A=5 returns 0 (the write was ignored).
- Assert cpurst_b low at cnt=7 of 16, release -> init_busy high for a full 16 cycles. Pre-reset write data at A=10 reads back as 0.
- INIT_ON_RESET=0: write A=2, D=0xFF. Pulse init_req -> init_busy 16 cycles, then read A=2 returns 0. A second init_req pulsed mid-fill does not extend busy.

Source files
------------

// File: rtl/ct_f_spsram_init_bw.sv
// Parametrised single-port SRAM model with masked writes, hardware zero-fill
// engine and a 1- or 2-cycle registered read path.
module ct_f_spsram_init_bw #(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned DATA_WIDTH    = 144,
    parameter int unsigned WEN_GRAN      = 1,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned INIT_ON_RESET = 1
) (
    input  logic                           forever_cpuclk,
    input  logic                           cpurst_b,
    input  logic [ADDR_WIDTH-1:0]          A,
    input  logic                           CEN,
    input  logic                           GWEN,
    input  logic [DATA_WIDTH/WEN_GRAN-1:0] WEN,
    input  logic [DATA_WIDTH-1:0]          D,
    output logic [DATA_WIDTH-1:0]          Q,
    output logic                           q_vld,
    input  logic                           init_req,
    output logic                           init_busy
);

    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam int unsigned WEN_WIDTH = DATA_WIDTH / WEN_GRAN;

    if (!(READ_LATENCY == 1 || READ_LATENCY == 2)) begin : g_bad_latency
        $error("ct_f_spsram_init_bw: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % WEN_GRAN != 0) begin : g_bad_gran
        $error("ct_f_spsram_init_bw: DATA_WIDTH must be a multiple of WEN_GRAN");
    end

    typedef enum logic {IDLE, INIT} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rdata;
    logic [DATA_WIDTH-1:0]   q_q;
    logic                    vld_q;
    logic                    acc, wr_acc, rd_acc;

    assign init_busy = (state_q == INIT);
    assign acc       = !CEN && !init_busy;
    assign wr_acc    = acc && !GWEN;
    assign rd_acc    = acc && GWEN;
    assign rdata     = mem[A];
    assign Q         = q_q;
    assign q_vld     = vld_q;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            if (INIT_ON_RESET != 0) state_q <= INIT;
            else                    state_q <= IDLE;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (init_req) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            INIT: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == '1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Array is deliberately not reset; the fill engine owns the port while busy.
    always_ff @(posedge forever_cpuclk) begin
        if (init_busy) begin
            mem[cnt_q] <= '0;
        end else if (wr_acc) begin
            for (int unsigned g = 0; g < WEN_WIDTH; g++) begin
                if (!WEN[g]) mem[A][g*WEN_GRAN +: WEN_GRAN] <= D[g*WEN_GRAN +: WEN_GRAN];
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s1_q;
        logic                  s1v_q;

        // Stage 1 is not gated by init_busy so an in-flight read still drains.
        always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
            if (!cpurst_b) begin
                s1_q  <= '0;
                s1v_q <= 1'b0;
                q_q   <= '0;
                vld_q <= 1'b0;
            end else begin
                s1v_q <= rd_acc;
                if (rd_acc) s1_q <= rdata;
                vld_q <= s1v_q;
                if (s1v_q) q_q <= s1_q;
            end
        end
    end else begin : g_lat1
        always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
            if (!cpurst_b) begin
                q_q   <= '0;
                vld_q <= 1'b0;
            end else begin
                vld_q <= rd_acc;
                if (rd_acc) q_q <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_ct_f_spsram_init_bw.sv
// Bench for ct_f_spsram_init_bw: one 1-cycle auto-init instance and one
// 2-cycle request-init instance, 16 x 16-bit arrays with byte write masks.
module tb_ct_f_spsram_init_bw;

    logic        clk;
    logic        rst_n;
    logic [3:0]  a;
    logic [15:0] d;
    logic [1:0]  wen;
    logic        gwen;
    logic        cen1, cen2;
    logic        init1, init2;
    logic [15:0] q1, q2;
    logic        qv1, qv2;
    logic        busy1, busy2;

    int total = 0;
    int bad   = 0;

    logic [15:0] ref_mem [16];

    ct_f_spsram_init_bw #(
        .ADDR_WIDTH(4), .DATA_WIDTH(16), .WEN_GRAN(8), .READ_LATENCY(1), .INIT_ON_RESET(1)
    ) dut1 (
        .forever_cpuclk(clk), .cpurst_b(rst_n), .A(a), .CEN(cen1), .GWEN(gwen),
        .WEN(wen), .D(d), .Q(q1), .q_vld(qv1), .init_req(init1), .init_busy(busy1)
    );

    ct_f_spsram_init_bw #(
        .ADDR_WIDTH(4), .DATA_WIDTH(16), .WEN_GRAN(8), .READ_LATENCY(2), .INIT_ON_RESET(0)
    ) dut2 (
        .forever_cpuclk(clk), .cpurst_b(rst_n), .A(a), .CEN(cen2), .GWEN(gwen),
        .WEN(wen), .D(d), .Q(q2), .q_vld(qv2), .init_req(init2), .init_busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts cycles until busy1 falls; optionally slips in a write while busy.
    task automatic wait_busy1(input bit inject, output int n);
        n = 0;
        while (busy1 && n < 40) begin
            if (inject && n == 3) begin
                a = 4'd5; d = 16'h0055; wen = 2'b00; gwen = 1'b0; cen1 = 1'b0;
            end else begin
                cen1 = 1'b1;
            end
            tick;
            n++;
        end
        cen1 = 1'b1;
    endtask

    // Counts cycles until busy2 falls; optionally re-pulses init_req mid-fill.
    task automatic wait_busy2(input bit repulse, output int n);
        n = 0;
        while (busy2 && n < 40) begin
            init2 = (repulse && n == 5);
            tick;
            n++;
        end
        init2 = 1'b0;
    endtask

    initial begin
        int          n;
        int          op;
        logic [15:0] pexp;
        logic [15:0] lastq;

        rst_n = 1'b0; a = '0; d = '0; wen = '1; gwen = 1'b1;
        cen1 = 1'b1; cen2 = 1'b1; init1 = 1'b0; init2 = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;

        // Reset state
        tick; tick; tick;
        chk("rst_q1", q1, 0);
        chk("rst_qv1", qv1, 0);
        chk("rst_busy1", busy1, 1);
        chk("rst_q2", q2, 0);
        chk("rst_qv2", qv2, 0);
        chk("rst_busy2", busy2, 0);

        // Auto-fill after release, with an ignored write to A=5 while busy
        rst_n = 1'b1;
        wait_busy1(1'b1, n);
        chk("init_len", n, 16);

        // Read every address back-to-back: all zero, one result per cycle
        for (int i = 0; i < 16; i++) begin
            a = 4'(i); gwen = 1'b1; cen1 = 1'b0;
            tick;
            chk($sformatf("zero_qv_%0d", i), qv1, 1);
            chk($sformatf("zero_q_%0d", i), q1, 0);
        end
        cen1 = 1'b1;
        tick;
        chk("zero_qv_end", qv1, 0);

        // Masked write: only the low byte lands
        a = 4'd3; d = 16'hABCD; wen = 2'b10; gwen = 1'b0; cen1 = 1'b0;
        ref_mem[3][7:0] = 8'hCD;
        tick;
        chk("wr_no_qv", qv1, 0);
        gwen = 1'b1;
        tick;
        cen1 = 1'b1;
        chk("mask_qv", qv1, 1);
        chk("mask_q", q1, 16'h00CD);
        tick;
        chk("mask_qv_pulse", qv1, 0);
        chk("mask_q_hold", q1, 16'h00CD);
        lastq = 16'h00CD;

        // Random traffic against the array model
        for (int i = 0; i < 150; i++) begin
            op  = int'($urandom_range(0, 2));
            a   = 4'($urandom);
            d   = 16'($urandom);
            wen = 2'($urandom);
            cen1 = (op == 0);
            gwen = (op == 2);
            if (op == 2) pexp = ref_mem[a];
            if (op == 1) begin
                if (!wen[0]) ref_mem[a][7:0]  = d[7:0];
                if (!wen[1]) ref_mem[a][15:8] = d[15:8];
            end
            tick;
            if (op == 2) begin
                chk($sformatf("rnd_qv_%0d", i), qv1, 1);
                chk($sformatf("rnd_q_%0d", i), q1, pexp);
                lastq = pexp;
            end else begin
                chk($sformatf("rnd_qv_%0d", i), qv1, 0);
                chk($sformatf("rnd_hold_%0d", i), q1, lastq);
            end
        end
        cen1 = 1'b1;

        // Requested fill aborted by reset at cnt=7; A=10 must still be cleared
        a = 4'd10; d = 16'h1234; wen = 2'b00; gwen = 1'b0; cen1 = 1'b0;
        tick;
        cen1 = 1'b1;
        init1 = 1'b1;
        tick;
        init1 = 1'b0;
        chk("req_busy1", busy1, 1);
        for (int i = 0; i < 7; i++) tick;
        rst_n = 1'b0;
        tick;
        chk("abort_busy1", busy1, 1);
        rst_n = 1'b1;
        wait_busy1(1'b0, n);
        chk("reinit_len", n, 16);
        a = 4'd10; gwen = 1'b1; cen1 = 1'b0;
        tick;
        cen1 = 1'b1;
        chk("abort_a10_qv", qv1, 1);
        chk("abort_a10_q", q1, 0);

        // Request-driven fill on the latency-2 instance
        a = 4'd2; d = 16'h00FF; wen = 2'b00; gwen = 1'b0; cen2 = 1'b0;
        tick;
        cen2 = 1'b1;
        init2 = 1'b1;
        tick;
        init2 = 1'b0;
        chk("req_busy2", busy2, 1);
        wait_busy2(1'b1, n);
        chk("req_len2", n, 16);
        a = 4'd2; gwen = 1'b1; cen2 = 1'b0;
        tick;
        cen2 = 1'b1;
        chk("l2_first_qv", qv2, 0);
        tick;
        chk("l2_a2_qv", qv2, 1);
        chk("l2_a2_q", q2, 0);
        tick;
        chk("l2_a2_pulse", qv2, 0);

        for (int k = 1; k <= 3; k++) begin
            a = 4'(k); d = 16'(k * 16'h11); wen = 2'b00; gwen = 1'b0; cen2 = 1'b0;
            tick;
        end
        for (int k = 1; k <= 3; k++) begin
            a = 4'(k); gwen = 1'b1; cen2 = 1'b0;
            tick;
            if (k == 1) begin
                chk("l2_pipe_qv0", qv2, 0);
            end else begin
                chk($sformatf("l2_pipe_qv%0d", k - 1), qv2, 1);
                chk($sformatf("l2_pipe_q%0d", k - 1), q2, 32'((k - 1) * 16'h11));
            end
        end
        cen2 = 1'b1;
        tick;
        chk("l2_pipe_qv3", qv2, 1);
        chk("l2_pipe_q3", q2, 16'h0033);
        tick;
        chk("l2_pipe_end", qv2, 0);
        chk("l2_pipe_hold", q2, 16'h0033);

        // Read sampled together with init_req still completes
        a = 4'd1; gwen = 1'b1; cen2 = 1'b0; init2 = 1'b1;
        tick;
        cen2 = 1'b1; init2 = 1'b0;
        chk("flight_busy", busy2, 1);
        chk("flight_qv0", qv2, 0);
        tick;
        chk("flight_qv", qv2, 1);
        chk("flight_q", q2, 16'h0011);
        wait_busy2(1'b0, n);
        chk("flight_len", n, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
